// File: rtl/input_conditioner.sv
// Input front end for the LED game: two-flop synchronisers and per-channel debounce for the
// slide switches and the active-low START key, plus press/change pulses and a one-hot flag.
module input_conditioner #(
  parameter int WIDTH        = 10,
  parameter int STABLE_COUNT = 50000,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] switch_raw,
  input  logic             start_raw,
  output logic [WIDTH-1:0] switch_out,
  output logic             start_out,
  output logic             start_press,
  output logic             switch_changed,
  output logic             switch_onehot
);

  // Channel WIDTH is the START key; it rests high, the switches rest low.
  localparam logic [WIDTH:0]   RST_VAL = {1'b1, {WIDTH{1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(STABLE_COUNT - 1);

  logic [WIDTH:0] sync1_r;
  logic [WIDTH:0] sync2_r;
  logic [WIDTH:0] out_s;
  logic [WIDTH:0] prev_r;
  logic           start_press_r;
  logic           switch_changed_r;

  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      multi = multi | (seen & v[i]);
      seen  = seen | v[i];
    end
    return seen & ~multi;
  endfunction

  // Two-flop synchroniser for all raw pins.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r <= RST_VAL;
      sync2_r <= RST_VAL;
    end else begin
      sync1_r <= {start_raw, switch_raw};
      sync2_r <= sync1_r;
    end
  end

  for (genvar g = 0; g <= WIDTH; g++) begin : g_chan
    logic             out_r;
    logic [CNT_W-1:0] cnt_r;

    // Debounce: commit the synchronised level after STABLE_COUNT disagreeing cycles.
    always_ff @(posedge clock) begin
      if (reset) begin
        out_r <= RST_VAL[g];
        cnt_r <= {CNT_W{1'b0}};
      end else if (sync2_r[g] == out_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == LAST) begin
        out_r <= sync2_r[g];
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end

    assign out_s[g] = out_r;
  end

  // Edge detection against the previous debounced levels; reset loads prev with the reset
  // levels so a forced return to rest never looks like an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_r           <= RST_VAL;
      start_press_r    <= 1'b0;
      switch_changed_r <= 1'b0;
    end else begin
      prev_r           <= out_s;
      start_press_r    <= prev_r[WIDTH] & ~out_s[WIDTH];
      switch_changed_r <= (prev_r[WIDTH-1:0] != out_s[WIDTH-1:0]);
    end
  end

  assign switch_out     = out_s[WIDTH-1:0];
  assign start_out      = out_s[WIDTH];
  assign start_press    = start_press_r;
  assign switch_changed = switch_changed_r;
  assign switch_onehot  = is_onehot(out_s[WIDTH-1:0]);

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: stimulus queues expected output events by cycle,
// a negedge monitor compares every observed output event (and requested snapshots).
module tb_input_conditioner;

  logic       clock;
  logic       reset;
  logic [9:0] switch_raw;
  logic       start_raw;
  logic [9:0] switch_out;
  logic       start_out;
  logic       start_press;
  logic       switch_changed;
  logic       switch_onehot;

  input_conditioner #(.WIDTH(10), .STABLE_COUNT(4), .CNT_W(3)) dut (
    .clock(clock), .reset(reset), .switch_raw(switch_raw), .start_raw(start_raw),
    .switch_out(switch_out), .start_out(start_out), .start_press(start_press),
    .switch_changed(switch_changed), .switch_onehot(switch_onehot)
  );

  typedef struct {
    int         cyc;
    logic [9:0] sw;
    logic       st;
    logic       pr;
    logic       ch;
    logic       oh;
    bit         frc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  bit   mon_en = 1'b0;
  bit   done = 1'b0;
  logic [9:0] last_sw = 10'd0;
  logic       last_st = 1'b1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic push(input int cy, input logic [9:0] sw, input logic st, input logic pr,
                      input logic ch, input logic oh, input bit frc);
    exp_t e;
    e.cyc = cy; e.sw = sw; e.st = st; e.pr = pr; e.ch = ch; e.oh = oh; e.frc = frc;
    q.push_back(e);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: an event is any level change or pulse; forced snapshots are compared regardless.
  always @(negedge clock) begin
    bit   evt;
    exp_t e;
    if (done) begin
      compared++;
      if (q.size() != 0) begin
        mismatched++;
        $display("FAIL pending_events: %0d left, required 0 (next at cycle %0d)", q.size(), q[0].cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
    end else if (mon_en) begin
      evt = (switch_out !== last_sw) || (start_out !== last_st) ||
            (start_press !== 1'b0) || (switch_changed !== 1'b0);
      last_sw = switch_out;
      last_st = start_out;
      if (evt || (q.size() > 0 && q[0].frc && q[0].cyc == cyc)) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_event: cycle %0d sw=%h st=%b pr=%b ch=%b oh=%b, required none",
                   cyc, switch_out, start_out, start_press, switch_changed, switch_onehot);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || switch_out !== e.sw || start_out !== e.st ||
              start_press !== e.pr || switch_changed !== e.ch || switch_onehot !== e.oh) begin
            mismatched++;
            $display("FAIL event: actual cycle %0d sw=%h st=%b pr=%b ch=%b oh=%b, required cycle %0d sw=%h st=%b pr=%b ch=%b oh=%b",
                     cyc, switch_out, start_out, start_press, switch_changed, switch_onehot,
                     e.cyc, e.sw, e.st, e.pr, e.ch, e.oh);
          end
        end
      end
    end
  end

  initial begin
    int c;
    reset      = 1'b1;
    switch_raw = 10'd0;
    start_raw  = 1'b1;
    wait_n(3);
    reset = 1'b0;
    c = cyc;
    push(c + 1,  10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(c + 20, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    wait_n(22);

    // Clean single switch
    c = cyc;
    switch_raw = 10'b0000100000;
    push(c + 6, 10'h020, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    push(c + 7, 10'h020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_n(12);

    // Bounce on bit 0 is rejected
    for (int i = 0; i < 8; i++) begin
      switch_raw[0] = (i % 2 == 0);
      wait_n(1);
    end
    switch_raw[0] = 1'b0;
    c = cyc;
    push(c + 8, 10'h020, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_n(12);

    // Start key held long: one press; release: no pulse
    c = cyc;
    start_raw = 1'b0;
    push(c + 6, 10'h020, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(c + 7, 10'h020, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_n(50);
    c = cyc;
    start_raw = 1'b1;
    push(c + 6, 10'h020, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_n(12);

    // Back to zero, then two bits on the same edge
    c = cyc;
    switch_raw = 10'd0;
    push(c + 6, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push(c + 7, 10'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_n(12);
    c = cyc;
    switch_raw = 10'b1000000001;
    push(c + 6, 10'h201, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push(c + 7, 10'h201, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_n(12);

    // Start press and switch change land on the same edge
    c = cyc;
    start_raw  = 1'b0;
    switch_raw = 10'h008;
    push(c + 6, 10'h008, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(c + 7, 10'h008, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_n(12);
    c = cyc;
    start_raw = 1'b1;
    push(c + 6, 10'h008, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_n(12);

    // Reset during the start debounce count; switches re-debounce afterwards
    c = cyc;
    start_raw = 1'b0;
    wait_n(4);
    reset = 1'b1;
    push(c + 5,  10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(c + 6,  10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(c + 11, 10'h008, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(c + 12, 10'h008, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_n(1);
    reset = 1'b0;
    wait_n(12);
    c = cyc;
    start_raw = 1'b1;
    push(c + 6, 10'h008, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_n(12);

    done = 1'b1;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Upstream front end of the LED game status FSM. It receives the raw slide switches and the raw START key from the board pins.
- Each input is synchronised to `clock` and debounced individually.
- Outputs are clean switch and start levels, a one-cycle press pulse and change pulse, and a one-hot qualifier. The game FSM consumes these in place of raw pins.
- This removes contact bounce from its input-match and start decisions.

Parameters:
- WIDTH, 10, number of slide switches.
- STABLE_COUNT, 50000, consecutive clock cycles an input must disagree with its output before the output updates (1 ms at 50 MHz). Must be >= 1.
- CNT_W, 16, debounce counter width. Must satisfy 2^CNT_W > STABLE_COUNT-1.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- switch_raw  input  WIDTH  asynchronous slide switch pins, 1 = up.
- start_raw  input  1  asynchronous START key, active-low (0 = pressed).
- switch_out  output  WIDTH  debounced switch levels.
- start_out  output  1  debounced START level, active-low, same polarity as start_raw.
- start_press  output  1  one-cycle pulse on debounced START press (start_out 1->0).
- switch_changed  output  1  one-cycle pulse when any switch_out bit changed.
- switch_onehot  output  1  1 when exactly one switch_out bit is 1.

Behaviour:
- Synchroniser:
  - Two-flop chain per input (s1, s2).
  - Reset values: switch flops 0, start flops 1 (released).
- Debounce, per channel, independent, one CNT_W counter each:
  - If s2 == out: counter <= 0.
  - If s2 != out and counter < STABLE_COUNT-1: counter <= counter+1.
  - If s2 != out and counter == STABLE_COUNT-1: out <= s2, counter <= 0.
- Debounce timing:
  - A raw level held stable appears on its output exactly STABLE_COUNT+2 rising edges after the first edge that samples it.
  - Any glitch shorter than STABLE_COUNT cycles at s2 resets the counter and is never propagated.
  - With STABLE_COUNT=1, out follows s2 with one cycle delay.
- start_press:
  - Registered. Asserted for exactly one cycle, the cycle after start_out goes 1->0.
  - No pulse on release (0->1).
  - A held key produces one pulse only.
- switch_changed:
  - Registered. Asserted one cycle after any bit of switch_out changes.
  - Several bits changing on the same edge give a single one-cycle pulse.
  - Bits changing on consecutive edges give back-to-back pulses.
- switch_onehot:
  - Combinational from registered switch_out: 1 iff popcount(switch_out) == 1.
  - 0 for all-zero and for two or more bits set.
- Reset values:
  - Register state: switch_out=0, start_out=1, all counters 0, synchroniser flops as above.
  - Pulse registers start_press=0, switch_changed=0 (also covers the reset-release cycle).
  - switch_onehot is 0 while switch_out=0 (it is combinational, not a reset register).
- Reset mid-operation:
  - Any in-progress debounce count is discarded.
  - Outputs return to reset values on the clocked edge.
  - The forced transition of start_out or switch_out to its reset value does not generate start_press or switch_changed, in the reset cycle or the following cycle.
- Simultaneous events:
  - All channels debounce in parallel.
  - A start press and a switch change on the same edge both pulse in the same cycle.
- Counter never wraps: it saturates by the clear-on-commit rule above.
- No combinational path from any raw input to any output.

Test Plan (STABLE_COUNT=4, CNT_W=3):
- Reset then idle, all raw inputs at rest values:
  - switch_raw=0, start_raw=1 for 20 cycles -> switch_out=0, start_out=1, no pulses, switch_onehot=0.
- Clean switch input:
  - switch_raw 0 -> 10'b0000100000, held -> switch_out updates on edge 6 after first sampling edge.
  - switch_changed=1 for exactly one cycle after that edge; switch_onehot=1.
- Bounce rejection:
  - switch_raw[0] toggles 1,0,1,0 each cycle for 8 cycles, then held at 0 -> switch_out[0] stays 0, switch_changed never asserts.
- Start key:
  - start_raw 1 -> 0 held 50 cycles -> start_out 1 -> 0 after 6 edges, single start_press pulse.
  - Release start_raw -> 1 -> start_out returns 1 after 6 edges, no pulse.
- Multi-bit change and onehot:
  - switch_raw 0 -> 10'b1000000001 on the same edge -> one switch_changed pulse, switch_onehot=0.
- Reset mid-debounce:
  - start_raw -> 0, assert reset for 1 cycle on cycle 3 of the count, keep start_raw=0 -> outputs at reset values, no pulses during reset.
  - start_out falls 6 edges after reset deasserts, then one start_press pulse.
